// File: rtl/clock_display.sv
// Six-digit multiplexed HH.MM.SS driver for an active-low 7-segment display.
// Time is snapshotted once per refresh frame; the field selected for editing blinks.
module clock_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [4:0] hour_in,
    input  logic [1:0] select,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    typedef enum logic [2:0] {
        D_SEC_U, D_SEC_T, D_MIN_U, D_MIN_T, D_HR_U, D_HR_T
    } digit_t;

    digit_t        digit_idx, digit_next;
    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase, phase_next;
    logic [5:0]    snap_sec, snap_min;
    logic [4:0]    snap_hour;
    logic [1:0]    prev_select;
    logic          first;
    logic          ref_last, frame_end, sel_changed, blink_last;
    logic [5:0]    field_val;
    logic          field_ok, use_tens, blank, dp_next;
    logic [1:0]    pair;
    logic [5:0]    an_onehot, an_next;
    logic [3:0]    digit_val;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

    always_comb begin
        ref_last    = (ref_cnt == REF_LAST);
        frame_end   = ref_last && (digit_idx == D_HR_T);
        sel_changed = (select != prev_select);
        blink_last  = (blink_cnt == BLINK_LAST);
        // select change wins over a coincident blink terminal count
        if (sel_changed)     phase_next = 1'b1;
        else if (blink_last) phase_next = ~blink_phase;
        else                 phase_next = blink_phase;
    end

    always_comb begin
        digit_next = digit_idx;
        if (ref_last) begin
            case (digit_idx)
                D_SEC_U: digit_next = D_SEC_T;
                D_SEC_T: digit_next = D_MIN_U;
                D_MIN_U: digit_next = D_MIN_T;
                D_MIN_T: digit_next = D_HR_U;
                D_HR_U:  digit_next = D_HR_T;
                default: digit_next = D_SEC_U;
            endcase
        end
    end

    always_comb begin
        field_val = '0;
        field_ok  = 1'b1;
        use_tens  = 1'b0;
        pair      = 2'd0;
        an_onehot = '1;
        dp_next   = 1'b1;
        case (digit_idx)
            D_SEC_U: begin field_val = snap_sec; pair = 2'd1; an_onehot = 6'b111110; end
            D_SEC_T: begin field_val = snap_sec; pair = 2'd1; an_onehot = 6'b111101; use_tens = 1'b1; end
            D_MIN_U: begin field_val = snap_min; pair = 2'd2; an_onehot = 6'b111011; dp_next = 1'b0; end
            D_MIN_T: begin field_val = snap_min; pair = 2'd2; an_onehot = 6'b110111; use_tens = 1'b1; end
            D_HR_U:  begin field_val = {1'b0, snap_hour}; pair = 2'd3; an_onehot = 6'b101111; dp_next = 1'b0; end
            D_HR_T:  begin field_val = {1'b0, snap_hour}; pair = 2'd3; an_onehot = 6'b011111; use_tens = 1'b1; end
            default: ;
        endcase
        if (pair == 2'd3) field_ok = (field_val <= 6'd23);
        else              field_ok = (field_val <= 6'd59);
        digit_val = use_tens ? 4'(field_val / 6'd10) : 4'(field_val % 6'd10);
        seg_next  = field_ok ? seg_code(digit_val) : SEG_DASH;
        // blanking follows the post-edge phase so a new selection shows at once
        blank     = (select != 2'd0) && !phase_next && (select == pair);
        an_next   = blank ? '1 : an_onehot;
    end

    always_ff @(posedge clk) begin
        prev_select <= select;
        if (!reset) begin
            ref_cnt     <= '0;
            digit_idx   <= D_SEC_U;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            snap_sec    <= '0;
            snap_min    <= '0;
            snap_hour   <= '0;
            first       <= 1'b1;
            an          <= '1;
            seg         <= '1;
            dp          <= 1'b1;
        end else begin
            first       <= 1'b0;
            ref_cnt     <= ref_last ? '0 : ref_cnt + 1'b1;
            digit_idx   <= digit_next;
            blink_cnt   <= (sel_changed || blink_last) ? '0 : blink_cnt + 1'b1;
            blink_phase <= phase_next;
            if (first || frame_end) begin
                snap_sec  <= sec_in;
                snap_min  <= min_in;
                snap_hour <= hour_in;
            end
            if (first) begin
                an  <= '1;
                seg <= '1;
                dp  <= 1'b1;
            end else begin
                an  <= an_next;
                seg <= seg_next;
                dp  <= dp_next;
            end
        end
    end
endmodule

// File: tb/tb_clock_display.sv
// Bench for clock_display: arithmetic reference model checked every edge,
// a digit table per frame, and hand sequences for reset, snapshot and blink.
module tb_clock_display;
    localparam int R = 4;
    localparam int B = 16;
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] sec_in = '0, min_in = '0;
    logic [4:0] hour_in = '0;
    logic [1:0] select = '0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    clock_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk(clk), .reset(reset), .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .select(select), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    // model: n = non-reset edges since last reset, s = edges since last blink restart
    int n = 0, s = 0, m_sec = 0, m_min = 0, m_hour = 0;
    logic [1:0] prev_sel = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int d, v, lim;
        bit vis, snap;
        int p_sec, p_min, p_hour;
        e_an = '1; e_seg = '1; e_dp = 1'b1;
        p_sec = int'(sec_in); p_min = int'(min_in); p_hour = int'(hour_in);
        if (!reset) begin
            @(posedge clk);
            n = 0; s = 0; m_sec = 0; m_min = 0; m_hour = 0;
        end else begin
            s = (select != prev_sel) ? 0 : s + 1;
            if (n != 0) begin
                d   = (n / R) % 6;
                v   = (d < 2) ? m_sec : (d < 4) ? m_min : m_hour;
                lim = (d < 4) ? 59 : 23;
                e_seg = (v > lim) ? DASH : SEG_TAB[(d % 2 == 0) ? v % 10 : v / 10];
                e_dp  = (d == 2 || d == 4) ? 1'b0 : 1'b1;
                vis   = ((s / B) % 2) == 0;
                if (!(select != 0 && !vis && int'(select) == d / 2 + 1)) e_an[d] = 1'b0;
            end
            snap = (n == 0) || (n % (6 * R) == 6 * R - 1);
            @(posedge clk);
            if (snap) begin m_sec = p_sec; m_min = p_min; m_hour = p_hour; end
            n++;
        end
        prev_sel = select;
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
    endtask

    function automatic int lit_digit(input logic [5:0] a);
        lit_digit = -1;
        for (int i = 0; i < 6; i++) begin
            logic [5:0] oh;
            oh = ~(6'b1 << i);
            if (a == oh) lit_digit = i;
        end
    endfunction

    typedef struct {
        logic [5:0]      sec;
        logic [5:0]      min;
        logic [4:0]      hour;
        logic [5:0][6:0] exp_seg;   // index = digit position
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cnt, seen, d;
        vecs[0] = '{6'd59, 6'd7, 5'd23, {7'b0100100, 7'b0110000, 7'b1000000, 7'b1111000, 7'b0010010, 7'b0010000}};
        vecs[1] = '{6'd60, 6'd7, 5'd24, {DASH, DASH, 7'b1000000, 7'b1111000, DASH, DASH}};
        vecs[2] = '{6'd0, 6'd0, 5'd0, {6{7'b1000000}}};
        vecs[3] = '{6'd34, 6'd18, 5'd6, {7'b1000000, 7'b0000010, 7'b1111001, 7'b0000000, 7'b0110000, 7'b0011001}};

        // reset with arbitrary inputs
        sec_in = 6'd13; min_in = 6'd42; hour_in = 5'd9; select = 2'd1;
        repeat (3) tick();
        check("reset_an", 32'(an), 32'h3F);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        select = 2'd0; sec_in = 6'd59; min_in = 6'd7; hour_in = 5'd23;
        reset = 1'b1;
        tick(); tick();
        check("release_an", 32'(an), 32'b111110);
        check("release_seg", 32'(seg), 32'b0010000);

        // digit table, one full frame per vector
        foreach (vecs[k]) begin
            sec_in = vecs[k].sec; min_in = vecs[k].min; hour_in = vecs[k].hour;
            repeat (6 * R) tick();
            seen = 0;
            for (int c = 0; c < 6 * R; c++) begin
                tick();
                d = lit_digit(an);
                if (d >= 0) begin
                    seen++;
                    check($sformatf("table%0d_d%0d", k, d), 32'(seg), 32'(vecs[k].exp_seg[d]));
                    check($sformatf("table%0d_dp%0d", k, d), 32'(dp), (d == 2 || d == 4) ? 32'h0 : 32'h1);
                end
            end
            check($sformatf("table%0d_frame_len", k), 32'(seen), 32'(6 * R));
        end

        // snapshot: change inputs during digit 1, current frame keeps old hour
        sec_in = 6'd59; min_in = 6'd7; hour_in = 5'd23;
        repeat (2 * 6 * R) tick();
        cnt = 0;
        while ((n / R) % 6 != 1 && cnt < 100) begin tick(); cnt++; end
        check("snap_align", 32'(cnt < 100), 32'h1);
        tick();
        sec_in = 6'd0; hour_in = 5'd0;
        cnt = 0;
        while ((n / R) % 6 != 5 && cnt < 100) begin tick(); cnt++; end
        tick();
        check("snap_old_hour", 32'(seg), 32'b0100100);
        cnt = 0;
        while ((n / R) % 6 != 0 && cnt < 100) begin tick(); cnt++; end
        tick();
        check("snap_new_sec", 32'(seg), 32'b1000000);

        // blink: minutes visible for B edges right after selection
        min_in = 6'd7;
        select = 2'd2;
        cnt = 0;
        for (int c = 0; c < B; c++) begin tick(); if (an == 6'h3F) cnt++; end
        check("blink_min_visible", 32'(cnt), 32'h0);
        cnt = 0;
        while (((s + 1) / B) % 2 != 1 && cnt < 200) begin tick(); cnt++; end
        tick();
        select = 2'd3;
        cnt = 0;
        for (int c = 0; c < B; c++) begin tick(); if (an == 6'h3F) cnt++; end
        check("blink_hour_visible", 32'(cnt), 32'h0);
        repeat (4 * B) tick();
        select = 2'd0;
        repeat (2 * B) tick();

        // reset in digit 3 while minutes are blanked
        select = 2'd2;
        tick();
        cnt = 0;
        while (!((n / R) % 6 == 3 && ((s + 1) / B) % 2 == 1) && cnt < 400) begin tick(); cnt++; end
        check("midreset_align", 32'(cnt < 400), 32'h1);
        reset = 1'b0;
        tick();
        check("midreset_an", 32'(an), 32'h3F);
        check("midreset_seg", 32'(seg), 32'h7F);
        check("midreset_dp", 32'(dp), 32'h1);
        reset = 1'b1;
        tick(); tick();
        check("restart_an", 32'(an), 32'b111110);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) sec_in = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) min_in = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) hour_in = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 40) == 0) select = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 300) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
